// File: rtl/unidade_controle_multiciclo_if.sv
// Control bus between the multicycle main FSM and the RV32I datapath.
// The controller uses the master modport; the datapath side uses slave.
interface unidade_controle_multiciclo_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pc_en;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        iord;
  logic        reg_write;
  logic        result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        pc_source;
  logic        illegal_instr;
  logic [3:0]  estado;

  modport master (
    input  instr, zero, mem_ready,
    output pc_en, ir_write, mem_read, mem_write, iord, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, pc_source, illegal_instr, estado
  );

  modport slave (
    output instr, zero, mem_ready,
    input  pc_en, ir_write, mem_read, mem_write, iord, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, pc_source, illegal_instr, estado
  );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle main control FSM for the RV32I subset lw/sw/R-type/andi/beq.
// Moore decode of state, except pc_en/ir_write which also follow mem_ready/zero.
module unidade_controle_multiciclo (
  input logic clk,
  input logic rst_n,
  unidade_controle_multiciclo_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_ILLEGAL   = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       pc_write;
  logic       branch;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LOAD || opcode == OP_STORE)        state_d = S_MEM_ADDR;
        else if (opcode == OP_RTYPE)                        state_d = S_EXEC_R;
        else if (opcode == OP_IMM && funct3 == 3'b111)      state_d = S_EXEC_I;
        else if (opcode == OP_BRANCH && funct3 == 3'b000)   state_d = S_BRANCH;
        else                                                state_d = S_ILLEGAL;
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_ILLEGAL:   state_d = S_ILLEGAL;
      default:     state_d = S_ILLEGAL;
    endcase
  end

  always_comb begin
    pc_write          = 1'b0;
    branch            = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.iord          = 1'b0;
    bus.reg_write     = 1'b0;
    bus.result_src    = 1'b0;
    bus.alu_src_a     = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 1'b0;
    bus.illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        pc_write      = bus.mem_ready;
        bus.ir_write  = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.result_src = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      S_EXEC_R: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 2'b11;
      end
      S_ALU_WB:  bus.reg_write = 1'b1;
      S_BRANCH: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b01;
        bus.pc_source = 1'b1;
        branch        = 1'b1;
      end
      default:   bus.illegal_instr = 1'b1;
    endcase

    bus.pc_en = pc_write | (branch & bus.zero);

    // Reset mid-instruction must not leak a partial write or PC/IR update.
    if (!rst_n) begin
      bus.pc_en     = 1'b0;
      bus.ir_write  = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.reg_write = 1'b0;
    end
  end

  assign bus.estado = state_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench: directed scenarios plus random instruction streams with
// random memory stalls, checked against a per-instruction expected state trace.
module tb_unidade_controle_multiciclo;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  unidade_controle_multiciclo_if ifc ();

  unidade_controle_multiciclo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  // Expected trace for the current instruction: one entry per clock cycle.
  int   seq_st[$];
  logic seq_rdy[$];

  localparam logic [31:0] I_ADD  = 32'h00B50533;
  localparam logic [31:0] I_LW   = 32'h0004A283;
  localparam logic [31:0] I_SW   = 32'h0054A023;
  localparam logic [31:0] I_ANDI = 32'h0FF57513;
  localparam logic [31:0] I_BEQ  = 32'h00B50463;
  localparam logic [31:0] I_ILL  = 32'h0000007F;
  localparam logic [31:0] I_ADDI = 32'h00150513;
  localparam logic [31:0] I_BNE  = 32'h00B51463;

  // Output vector layout: pc_en ir_write mem_read mem_write iord reg_write
  // result_src alu_src_a[2] alu_src_b[2] alu_op[2] pc_source illegal_instr
  function automatic logic [14:0] exp_outs(input int st, input logic rdy,
                                           input logic z, input logic in_reset);
    logic pe = 0, irw = 0, mr = 0, mw = 0, io = 0, rw = 0, rs = 0, ps = 0, il = 0;
    logic [1:0] sa = 2'b00, sb = 2'b00, op = 2'b00;
    case (st)
      0:  begin pe = rdy; irw = rdy; mr = 1; sb = 2'b01; end
      1:  begin sa = 2'b01; sb = 2'b10; end
      2:  begin sa = 2'b10; sb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; rs = 1; end
      5:  begin mw = 1; io = 1; end
      6:  begin sa = 2'b10; op = 2'b10; end
      7:  begin sa = 2'b10; sb = 2'b10; op = 2'b11; end
      8:  rw = 1;
      9:  begin sa = 2'b10; op = 2'b01; ps = 1; pe = z; end
      default: il = 1;
    endcase
    if (in_reset) begin
      pe = 0; irw = 0; mr = 0; mw = 0; rw = 0;
    end
    return {pe, irw, mr, mw, io, rw, rs, sa, sb, op, ps, il};
  endfunction

  function automatic logic [14:0] obs_outs();
    return {ifc.pc_en, ifc.ir_write, ifc.mem_read, ifc.mem_write, ifc.iord,
            ifc.reg_write, ifc.result_src, ifc.alu_src_a, ifc.alu_src_b,
            ifc.alu_op, ifc.pc_source, ifc.illegal_instr};
  endfunction

  // 0 lw, 1 sw, 2 R-type, 3 andi, 4 beq, 5 illegal
  function automatic int classify(input logic [31:0] ins);
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    if (opc == 7'b0000011) return 0;
    if (opc == 7'b0100011) return 1;
    if (opc == 7'b0110011) return 2;
    if (opc == 7'b0010011 && f3 == 3'b111) return 3;
    if (opc == 7'b1100011 && f3 == 3'b000) return 4;
    return 5;
  endfunction

  task automatic checkOutput(input string tag, input int st, input logic rdy,
                             input logic z, input logic in_reset);
    logic [3:0]  exp_st = 4'(st);
    logic [14:0] exp_v  = exp_outs(st, rdy, z, in_reset);
    logic [14:0] obs_v  = obs_outs();
    n_assert++;
    assert (ifc.estado === exp_st)
    else begin
      n_fail++;
      $error("[TB] FAIL %s estado: observed %0d expected %0d", tag, ifc.estado, exp_st);
    end
    n_assert++;
    assert (obs_v === exp_v)
    else begin
      n_fail++;
      $error("[TB] FAIL %s outputs (state %0d): observed %b expected %b", tag, st, obs_v, exp_v);
    end
  endtask

  task automatic applyStimulus(input int st, input logic rdy, input logic z, input string tag);
    @(negedge clk);
    ifc.mem_ready = rdy;
    ifc.zero      = z;
    #1;
    checkOutput(tag, st, rdy, z, 1'b0);
  endtask

  task automatic push_wait(input int st, input int stall);
    repeat (stall) begin seq_st.push_back(st); seq_rdy.push_back(1'b0); end
    seq_st.push_back(st);
    seq_rdy.push_back(1'b1);
  endtask

  task automatic push_plain(input int st);
    seq_st.push_back(st);
    seq_rdy.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic build_seq(input logic [31:0] ins, input int fstall, input int mstall);
    seq_st.delete();
    seq_rdy.delete();
    push_wait(0, fstall);
    push_plain(1);
    case (classify(ins))
      0: begin push_plain(2); push_wait(3, mstall); push_plain(4); end
      1: begin push_plain(2); push_wait(5, mstall); end
      2: begin push_plain(6); push_plain(8); end
      3: begin push_plain(7); push_plain(8); end
      4: push_plain(9);
      default: push_plain(15);
    endcase
  endtask

  // zsel < 0 randomizes zero every cycle, otherwise zero is held at zsel.
  task automatic run_seq(input logic [31:0] ins, input int zsel, input string tag);
    ifc.instr = ins;
    foreach (seq_st[i])
      applyStimulus(seq_st[i], seq_rdy[i],
                    (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel), tag);
  endtask

  task automatic do_reset(input int cur_st, input int edges, input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    ifc.mem_ready = 1'b0;
    #1;
    checkOutput(tag, cur_st, 1'b0, ifc.zero, 1'b1);
    repeat (edges) begin
      @(posedge clk);
      #1;
      checkOutput(tag, 0, ifc.mem_ready, ifc.zero, 1'b1);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] ins;
    logic [31:0] pool [8];
    pool = '{I_LW, I_SW, I_ADD, I_ANDI, I_BEQ, I_ILL, I_ADDI, I_BNE};

    rst_n         = 1'b0;
    ifc.mem_ready = 1'b1;
    ifc.zero      = 1'b0;
    ifc.instr     = I_ADD;
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("reset", 0, 1'b1, 1'b0, 1'b1);
    end
    rst_n = 1'b1;

    build_seq(I_ADD, 0, 0);
    run_seq(I_ADD, -1, "rtype");

    build_seq(I_LW, 0, 2);
    run_seq(I_LW, -1, "lw_stall");

    build_seq(I_BEQ, 0, 0);
    run_seq(I_BEQ, 1, "beq_taken");
    build_seq(I_BEQ, 0, 0);
    run_seq(I_BEQ, 0, "beq_not_taken");

    build_seq(I_ILL, 0, 0);
    repeat (9) push_plain(15);
    run_seq(I_ILL, -1, "illegal_hold");
    do_reset(15, 2, "illegal_clear");

    ifc.instr = I_SW;
    applyStimulus(0, 1'b1, 1'b0, "sw_reset");
    applyStimulus(1, 1'b0, 1'b0, "sw_reset");
    applyStimulus(2, 1'b1, 1'b0, "sw_reset");
    applyStimulus(5, 1'b0, 1'b0, "sw_reset");
    applyStimulus(5, 1'b0, 1'b0, "sw_reset");
    do_reset(5, 1, "sw_reset_mid");

    for (int n = 0; n < 60; n++) begin
      ins = pool[$urandom_range(0, 7)];
      ins = ($urandom & 32'hFFFF8F80) | (ins & 32'h0000707F);
      build_seq(ins, $urandom_range(0, 2), $urandom_range(0, 3));
      if (classify(ins) == 5) begin
        repeat ($urandom_range(1, 3)) push_plain(15);
        run_seq(ins, -1, "rand_illegal");
        do_reset(15, $urandom_range(1, 2), "rand_reset");
      end else begin
        run_seq(ins, -1, "rand_instr");
      end
    end

    build_seq(I_ANDI, 1, 0);
    run_seq(I_ANDI, -1, "andi_final");
    applyStimulus(0, 1'b0, 1'b0, "final_fetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/unidade_controle_multiciclo.md
Name: unidade_controle_multiciclo

Overview:
- Multicycle main control FSM for the RV32I datapath subset: lw, sw, R-type, andi, beq.
- Sits directly upstream of the ALU control decoder. Its alu_op output drives that decoder's 2-bit ALUOp; instr[31:25]/[14:12] feed its funct7/funct3.
- Generates all datapath enables and mux selects per state. Waits on a memory ready handshake and traps illegal opcodes.

Parameters:
- none (state and opcode encodings are fixed constants below).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- instr  input  32  current IR contents; opcode = instr[6:0], funct3 = instr[14:12].
- zero  input  1  ALU zero flag, same cycle.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_en  output  1  PC load = pc_write | (branch & zero).
- ir_write  output  1  load IR and OldPC.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- iord  output  1  address mux: 0 = PC, 1 = ALUOut.
- reg_write  output  1  register file write enable.
- result_src  output  1  writeback data: 0 = ALUOut, 1 = MemData.
- alu_src_a  output  2  00 = PC, 01 = OldPC, 10 = register A.
- alu_src_b  output  2  00 = register B, 01 = constant 4, 10 = immediate.
- alu_op  output  2  00 = ADD, 01 = SUB, 10 = R-type decode, 11 = AND.
- pc_source  output  1  PC input: 0 = ALU result, 1 = ALUOut.
- illegal_instr  output  1  sticky trap flag.
- estado  output  4  current state, for debug and verification.

Behaviour:
- Synchronous active-low reset: at a rising edge with rst_n=0, state becomes FETCH (0).
- While rst_n=0, pc_en, ir_write, mem_read, mem_write and reg_write are forced to 0 combinationally. This covers reset asserted mid-instruction; no partial write may occur.
- Outputs are Moore decode of state. Exceptions: pc_en and ir_write also depend on mem_ready/zero. Any output not listed for a state is 0.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, ILLEGAL 15. Codes 10-14 are unused and go to ILLEGAL.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=0.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADDR
  - 0110011 -> EXEC_R
  - 0010011 with funct3=111 -> EXEC_I
  - 1100011 with funct3=000 -> BRANCH
  - anything else -> ILLEGAL
- MEM_ADDR: alu_src_a=10, alu_src_b=10, alu_op=00. Goes to MEM_READ if opcode=0000011, else MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, result_src=1. Then FETCH.
- MEM_WRITE: mem_write=1, iord=1. Waits for mem_ready, then FETCH.
  - mem_write stays high through the stall and drops in the cycle after mem_ready.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10. Then ALU_WB.
- EXEC_I: alu_src_a=10, alu_src_b=10, alu_op=11. Then ALU_WB.
- ALU_WB: reg_write=1, result_src=0. Then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, branch=1, pc_source=1. pc_en = zero. Then FETCH.
- ILLEGAL: all enables 0, illegal_instr=1. Stays until reset; illegal_instr is cleared only by reset.
- Latency with mem_ready always 1: lw 5 cycles, sw 4, R-type 4, andi 4, beq 3. Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- mem_ready is ignored in all other states.
- instr must stay stable after DECODE; the FSM re-reads opcode in MEM_ADDR.

Test Plan:
- Reset: hold rst_n=0 for 2 edges, mem_ready=1 -> estado=0, every enable 0 while low. The first cycle after release is FETCH with mem_read=1, pc_en=1, ir_write=1.
- R-type: instr=0x00B50533 (add), mem_ready=1 -> estado 0,1,6,8,0. alu_op=10 in state 6; reg_write=1 only in state 8.
- lw with stall: instr=0x0004A283, mem_ready low for 2 cycles in MEM_READ -> estado 0,1,2,3,3,3,4,0. mem_read=1 and iord=1 in all state-3 cycles; result_src=1 in state 4.
- beq: instr=0x00B50463 with zero=1 -> pc_en=1 in BRANCH, pc_source=1, alu_op=01. Repeat with zero=0 -> pc_en=0. Both return to FETCH after 3 cycles.
- Illegal: instr opcode 1111111 -> DECODE then estado=15, illegal_instr=1, no enables, held for 10 cycles. rst_n=0 clears it.
- Reset mid-sw: assert rst_n=0 while in MEM_WRITE with mem_ready=0 -> mem_write drops to 0 immediately and estado=0 after the edge.
